// File: rtl/td4_control.sv
`default_nettype none
// ============================================================================
// Module   : td4_control
// Purpose  : TD4 instruction decode plus run/pause/single-step/halt control.
//            Decodes the ROM byte at the current PC into register load
//            strobes, source select and immediate with zero latency. Pause
//            and halt issue "JMP addr_rom" so REGISTERS needs no clock enable.
// Revision : 1.0  initial release
// ============================================================================
module td4_control #(
    parameter int RUN_ON_RESET = 1,
    parameter int CNT_WIDTH    = 16,
    parameter int HALT_DETECT  = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 run,
    input  logic                 step,
    input  logic [7:0]           rom_data,
    input  logic [3:0]           addr_rom,
    input  logic                 carry_n,
    output logic [3:0]           load_n,
    output logic [1:0]           select,
    output logic [3:0]           immed,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam state_t         c_RESET_STATE = (RUN_ON_RESET != 0) ? ST_RUN : ST_PAUSE;
    localparam [CNT_WIDTH-1:0] c_CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam [CNT_WIDTH-1:0] c_CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic                 r_step_d;
    logic                 r_exec_d;
    logic                 r_carry_hold;
    logic                 r_illegal;
    logic [CNT_WIDTH-1:0] r_retired;

    logic [3:0] w_opcode;
    logic [3:0] w_im;
    logic       w_exec;
    logic       w_carry_eff;
    logic       w_step_rise;
    logic [3:0] w_dec_load_n;
    logic [1:0] w_dec_select;
    logic [3:0] w_dec_immed;
    logic       w_dec_illegal;
    logic       w_dec_jump;
    logic       w_halt_hit;

    assign w_opcode    = rom_data[7:4];
    assign w_im        = rom_data[3:0];
    assign w_exec      = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_step_rise = step & ~r_step_d;
    // The cycle after a pause, REGISTERS has cleared carry; use the value
    // captured from the last executed instruction instead.
    assign w_carry_eff = r_exec_d ? carry_n : r_carry_hold;

    // Instruction decode of the current ROM byte; w_dec_jump flags a taken jump.
    always_comb begin
        w_dec_load_n  = 4'b1111;
        w_dec_select  = 2'b00;
        w_dec_immed   = w_im;
        w_dec_illegal = 1'b0;
        w_dec_jump    = 1'b0;
        case (w_opcode)
            4'h0: begin w_dec_load_n = 4'b1110; w_dec_select = 2'b00; end
            4'h1: begin w_dec_load_n = 4'b1110; w_dec_select = 2'b01; end
            4'h2: begin w_dec_load_n = 4'b1110; w_dec_select = 2'b10; end
            4'h3: begin w_dec_load_n = 4'b1110; w_dec_select = 2'b11; end
            4'h4: begin w_dec_load_n = 4'b1101; w_dec_select = 2'b00; end
            4'h5: begin w_dec_load_n = 4'b1101; w_dec_select = 2'b01; end
            4'h6: begin w_dec_load_n = 4'b1101; w_dec_select = 2'b10; end
            4'h7: begin w_dec_load_n = 4'b1101; w_dec_select = 2'b11; end
            4'h9: begin w_dec_load_n = 4'b1011; w_dec_select = 2'b01; end
            4'hB: begin w_dec_load_n = 4'b1011; w_dec_select = 2'b11; end
            4'hF: begin
                w_dec_load_n = 4'b0111;
                w_dec_select = 2'b11;
                w_dec_jump   = 1'b1;
            end
            4'hE: begin
                w_dec_select = 2'b11;
                if (w_carry_eff) begin
                    w_dec_load_n = 4'b0111;
                    w_dec_jump   = 1'b1;
                end else begin
                    w_dec_load_n = 4'b1111;
                end
            end
            default: begin
                // Undefined opcodes (8, A, C, D) retire as NOPs.
                w_dec_load_n  = 4'b1111;
                w_dec_select  = 2'b00;
                w_dec_immed   = 4'h0;
                w_dec_illegal = 1'b1;
            end
        endcase
    end

    generate
        if (HALT_DETECT != 0) begin : g_halt_detect
            assign w_halt_hit = w_exec && w_dec_jump && (w_im == addr_rom);
        end else begin : g_no_halt_detect
            assign w_halt_hit = 1'b0;
        end
    endgenerate

    // Output select: decoded instruction when executing, else "JMP addr_rom".
    always_comb begin
        if (w_exec) begin
            load_n = w_dec_load_n;
            select = w_dec_select;
            immed  = w_dec_immed;
        end else begin
            load_n = 4'b0111;
            select = 2'b11;
            immed  = addr_rom;
        end
    end

    assign halted  = (r_state == ST_HALT);
    assign illegal = r_illegal;
    assign retired = r_retired;

    // Run-control state machine with carry preservation and retire counting.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= c_RESET_STATE;
            r_step_d     <= 1'b0;
            r_exec_d     <= 1'b0;
            r_carry_hold <= 1'b1;
            r_illegal    <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_step_d <= step;
            r_exec_d <= w_exec;
            if (r_exec_d) begin
                r_carry_hold <= carry_n;
            end
            if (w_exec) begin
                if (r_retired != c_CNT_MAX) begin
                    r_retired <= r_retired + c_CNT_ONE;
                end
                if (w_dec_illegal) begin
                    r_illegal <= 1'b1;
                end
            end
            if (w_halt_hit) begin
                r_state <= ST_HALT;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (!run) begin
                            r_state <= ST_PAUSE;
                        end
                    end
                    ST_STEP: begin
                        r_state <= ST_PAUSE;
                    end
                    ST_PAUSE: begin
                        if (run) begin
                            r_state <= ST_RUN;
                        end else if (w_step_rise) begin
                            r_state <= ST_STEP;
                        end
                    end
                    default: begin
                        r_state <= ST_HALT;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_td4_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_td4_control
// Purpose  : Directed self-checking bench for td4_control. A second instance
//            (pause on reset, no halt detect, 3-bit counter) covers the
//            alternate parameter set and counter saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_td4_control;

    logic       clk;
    logic       clr;
    logic       run;
    logic       step;
    logic [7:0] rom_data;
    logic [3:0] addr_rom;
    logic       carry_n;
    logic [3:0] load_n;
    logic [1:0] select;
    logic [3:0] immed;
    logic       halted;
    logic       illegal;
    logic [15:0] retired;

    logic       run2;
    logic       step2;
    logic [7:0] rom2;
    logic [3:0] addr2;
    logic       carry2;
    logic [3:0] load_n2;
    logic [1:0] select2;
    logic [3:0] immed2;
    logic       halted2;
    logic       illegal2;
    logic [2:0] retired2;

    int n_checks;
    int n_errors;
    int n_exec;

    td4_control #(.RUN_ON_RESET(1), .CNT_WIDTH(16), .HALT_DETECT(1)) u_dut (
        .clk(clk), .clr(clr), .run(run), .step(step), .rom_data(rom_data),
        .addr_rom(addr_rom), .carry_n(carry_n), .load_n(load_n), .select(select),
        .immed(immed), .halted(halted), .illegal(illegal), .retired(retired)
    );

    td4_control #(.RUN_ON_RESET(0), .CNT_WIDTH(3), .HALT_DETECT(0)) u_dut2 (
        .clk(clk), .clr(clr), .run(run2), .step(step2), .rom_data(rom2),
        .addr_rom(addr2), .carry_n(carry2), .load_n(load_n2), .select(select2),
        .immed(immed2), .halted(halted2), .illegal(illegal2), .retired(retired2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_exec   = 0;
        clr = 1'b1; run = 1'b1; step = 1'b0; rom_data = 8'h35; addr_rom = 4'h0; carry_n = 1'b1;
        run2 = 1'b0; step2 = 1'b0; rom2 = 8'h35; addr2 = 4'h6; carry2 = 1'b1;

        // 1: reset state, RUN decodes MOV A,5 immediately
        #3;
        chk("rst_load_n", load_n, 4'b1110);
        chk("rst_select", select, 2'b11);
        chk("rst_immed", immed, 4'b0101);
        chk("rst_halted", halted, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_retired", retired, 16'd0);
        chk("rst2_load_n", load_n2, 4'b0111);
        chk("rst2_immed", immed2, 4'h6);
        #1 clr = 1'b0;
        cyc();
        chk("t1_retired", retired, 16'd1);

        // 2: JNC with and without carry
        rom_data = 8'hE7; carry_n = 1'b1;
        #1;
        chk("t2_jnc_taken", load_n, 4'b0111);
        chk("t2_jnc_immed", immed, 4'b0111);
        carry_n = 1'b0;
        #1;
        chk("t2_jnc_not", load_n, 4'b1111);
        chk("t2_jnc_sel", select, 2'b11);
        cyc();
        chk("t2_retired", retired, 16'd2);

        // 3: run low -> this instruction executes, then hold pattern
        rom_data = 8'h35; addr_rom = 4'h6; run = 1'b0; carry_n = 1'b1;
        #1;
        chk("t3_last_exec", load_n, 4'b1110);
        cyc();
        chk("t3_retired", retired, 16'd3);
        chk("t3_hold_load", load_n, 4'b0111);
        chk("t3_hold_sel", select, 2'b11);
        chk("t3_hold_imm", immed, 4'b0110);
        cyc();
        cyc();
        chk("t3_frozen", retired, 16'd3);

        // 4: step held for 5 clocks gives exactly one instruction
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (load_n == 4'b1110) n_exec++;
        end
        step = 1'b0;
        chk("t4_exec_cnt", n_exec, 1);
        chk("t4_retired", retired, 16'd4);
        chk("t4_paused", load_n, 4'b0111);

        // 5: carry survives a pause and is seen by JNC after resume
        run = 1'b1;
        cyc();
        rom_data = 8'h01; run = 1'b0;
        #1;
        chk("t5_add_load", load_n, 4'b1110);
        chk("t5_add_imm", immed, 4'b0001);
        cyc();
        carry_n = 1'b0;
        cyc();
        carry_n = 1'b1;
        cyc();
        cyc();
        cyc();
        run = 1'b1;
        cyc();
        rom_data = 8'hE2;
        #1;
        chk("t5_jnc_held", load_n, 4'b1111);
        chk("t5_retired", retired, 16'd5);
        cyc();
        chk("t5_jnc_live", load_n, 4'b0111);
        chk("t5_retired2", retired, 16'd6);

        // 6: self-jump halt, hold until clr, then illegal opcode
        rom_data = 8'hF3; addr_rom = 4'h3;
        #1;
        chk("t6_pre_halt", halted, 1'b0);
        cyc();
        chk("t6_halted", halted, 1'b1);
        chk("t6_hold_imm", immed, 4'h3);
        chk("t6_retired", retired, 16'd7);
        addr_rom = 4'h9; rom_data = 8'h35; step = 1'b1;
        cyc();
        step = 1'b0;
        chk("t6_still_halt", halted, 1'b1);
        chk("t6_hold_load", load_n, 4'b0111);
        chk("t6_hold_imm2", immed, 4'h9);
        chk("t6_frozen", retired, 16'd7);
        #2 clr = 1'b1;
        #1;
        chk("t6_clr_halt", halted, 1'b0);
        chk("t6_clr_ret", retired, 16'd0);
        clr = 1'b0;
        rom_data = 8'h80;
        #1;
        chk("t6_ill_load", load_n, 4'b1111);
        chk("t6_ill_sel", select, 2'b00);
        chk("t6_ill_imm", immed, 4'h0);
        chk("t6_ill_pre", illegal, 1'b0);
        cyc();
        chk("t6_ill_set", illegal, 1'b1);
        rom_data = 8'h35;
        cyc();
        chk("t6_ill_sticky", illegal, 1'b1);

        // Alternate instance: no halt on self-jump, counter saturates at 7
        run2 = 1'b1; rom2 = 8'hF6; addr2 = 4'h6;
        cyc();
        chk("p2_retired0", retired2, 3'd0);
        for (int i = 0; i < 9; i++) cyc();
        chk("p2_no_halt", halted2, 1'b0);
        chk("p2_jmp_load", load_n2, 4'b0111);
        chk("p2_saturate", retired2, 3'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
